// File: rtl/decrementer_seq.sv
// Loadable WIDTH-bit down-counter with run/stop control and a registered one-cycle done pulse.
// Optional free-running wrap mode with a borrow pulse is compiled in via DECREMENTER_WRAP_EN.
module decrementer_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             borrow
);

`ifdef DECREMENTER_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] start_val;

  assign count_dec = count_q - WIDTH'(1);
  // A simultaneous load makes the start decision on the value being loaded.
  assign start_val = load ? load_val : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) count_q <= load_val;
          if (start) begin
            if (start_val != '0 || WrapEn) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (load) begin
            count_q <= load_val;
            if (load_val == '0 && !WrapEn) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end else if (stop) begin
            state_q <= StIdle;
          end else begin
            count_q <= count_dec;
            if (count_q == WIDTH'(1) && !WrapEn) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              busy_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (load) count_q <= load_val;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef DECREMENTER_WRAP_EN
  logic borrow_q;

  // Flags the cycle in which count holds all-ones right after stepping down from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= (state_q == StRun) && !load && !stop && (count_q == '0);
    end
  end

  assign borrow = borrow_q;
`else
  assign borrow = 1'b0;
`endif

endmodule

// File: tb/tb_decrementer_seq.sv
// Directed bench for decrementer_seq; wrap-mode steps run when DECREMENTER_WRAP_EN is defined.
module tb_decrementer_seq;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             borrow;

  int total;
  int bad;

  decrementer_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks count, busy, done and borrow together.
  task automatic chk_all(input string tag, input logic [WIDTH-1:0] c, input logic b,
                         input logic d, input logic w);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".borrow"}, 32'(borrow), 32'(w));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    #1;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-countdown clears outputs in the same timestep.
    load = 1'b1; load_val = 4'd7; tick();
    load = 1'b0; start = 1'b1; tick();
    start = 1'b0;
    chk_all("rst_run", 4'd7, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    stop = 1'b1; tick(); stop = 1'b0;
    chk_all("idle_stop_ign", 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef DECREMENTER_WRAP_EN
    // Start from zero enters RUN and wraps.
    start = 1'b1; tick(); start = 1'b0;
    chk_all("w0_run", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w0_wrap", 4'd15, 1'b1, 1'b0, 1'b1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_all("w0_stop", 4'd15, 1'b0, 1'b0, 1'b0);

    load = 1'b1; load_val = 4'd1; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk_all("w_c1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c15", 4'd15, 1'b1, 1'b0, 1'b1);
    tick(); chk_all("w_c14", 4'd14, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_all("w_stop", 4'd14, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("w_hold", 4'd14, 1'b0, 1'b0, 1'b0);
`else
    // Load 5 then start: 5,4,3,2,1 busy, then done with count 0.
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    chk_all("a_loaded", 4'd5, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_all("a_c5", 4'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_all("a_cnt", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk_all("a_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("a_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Load 0 with start goes straight to DONE without wrapping.
    load = 1'b1; load_val = 4'd0; start = 1'b1; tick();
    load = 1'b0; start = 1'b0;
    chk_all("b_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("b_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Load in DONE applies; start in DONE is ignored.
    start = 1'b1; tick(); start = 1'b0;
    chk_all("b2_done", 4'd0, 1'b0, 1'b1, 1'b0);
    load = 1'b1; load_val = 4'd3; start = 1'b1; tick();
    load = 1'b0; start = 1'b0;
    chk_all("b2_load", 4'd3, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("b2_idle", 4'd3, 1'b0, 1'b0, 1'b0);

    // Stop at 6 freezes the count, then resume to done.
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk_all("c_c9", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_all("c_c6", 4'd6, 1'b1, 1'b0, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_all("c_stop", 4'd6, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("c_hold", 4'd6, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_all("c_resume", 4'd6, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i >= 1; i--) begin
      tick();
      chk_all("c_cnt", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk_all("c_done", 4'd0, 1'b0, 1'b1, 1'b0);

    // Load beats stop in RUN; done arrives 12 cycles after loading 12.
    tick();
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_all("d_c3", 4'd3, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'd12; stop = 1'b1; tick();
    load = 1'b0; stop = 1'b0;
    chk_all("d_c12", 4'd12, 1'b1, 1'b0, 1'b0);
    for (int i = 11; i >= 1; i--) begin
      tick();
      chk_all("d_cnt", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    tick(); chk_all("d_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("d_idle", 4'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
